// File: rtl/result_streamer.sv
// Streams the shortest-distance table out of OutputMemory over a valid/ready port
// once bellmanford finishes, or emits a single negative-cycle status beat instead.
module result_streamer #(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    COUNT      = 8192,
    parameter logic [DATA_WIDTH-1:0] INF_VALUE  = 16'hFFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  Finish,
    input  logic                  NegCycle,
    output logic [ADDR_WIDTH-1:0] OMAR,
    input  logic [DATA_WIDTH-1:0] OMDR,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_unreachable,
    output logic                  out_last,
    output logic                  out_neg,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STREAM  = 3'd1,
        DRAIN   = 3'd2,
        NEGBEAT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COUNT - 1);

    state_t                  state_r, state_s;
    logic                    fin_r, neg_r;
    logic                    start_fin_s, start_neg_s, load_s, hshake_s;
    logic [ADDR_WIDTH-1:0]   omar_s, index_s;
    logic [DATA_WIDTH-1:0]   data_s;
    logic                    valid_s, unreach_s, last_s, neg_s, busy_s, done_s;

    assign start_fin_s = Finish & ~fin_r;
    assign start_neg_s = NegCycle & ~neg_r;
    assign load_s      = ~out_valid | out_ready;
    assign hshake_s    = out_valid & out_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection; a negative-cycle edge takes priority over completion
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_neg_s) begin
                    state_s = NEGBEAT;
                end else if (start_fin_s) begin
                    state_s = STREAM;
                end else begin
                    state_s = state_r;
                end
            end
            STREAM: begin
                if (load_s && (OMAR == LAST_ADDR)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN, NEGBEAT: begin
                if (hshake_s) begin
                    state_s = DONE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; OMAR doubles as the stream address
    always_comb begin
        omar_s    = OMAR;
        valid_s   = out_valid;
        data_s    = out_data;
        index_s   = out_index;
        unreach_s = out_unreachable;
        last_s    = out_last;
        neg_s     = out_neg;
        busy_s    = busy;
        done_s    = done;
        case (state_r)
            IDLE, DONE: begin
                if (start_neg_s) begin
                    done_s = 1'b0;
                    busy_s = 1'b1;
                end else if (start_fin_s) begin
                    omar_s = {ADDR_WIDTH{1'b0}};
                    done_s = 1'b0;
                    busy_s = 1'b1;
                end else begin
                    done_s = done;
                end
            end
            STREAM: begin
                if (load_s) begin
                    valid_s   = 1'b1;
                    data_s    = OMDR;
                    index_s   = OMAR;
                    unreach_s = (OMDR == INF_VALUE);
                    last_s    = (OMAR == LAST_ADDR);
                    neg_s     = 1'b0;
                    // Park on the final address so OMAR never wraps
                    if (OMAR == LAST_ADDR) begin
                        omar_s = OMAR;
                    end else begin
                        omar_s = OMAR + ADDR_WIDTH'(1);
                    end
                end else begin
                    omar_s = OMAR;
                end
            end
            DRAIN: begin
                if (hshake_s) begin
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    valid_s = out_valid;
                end
            end
            NEGBEAT: begin
                if (!out_valid) begin
                    valid_s   = 1'b1;
                    neg_s     = 1'b1;
                    last_s    = 1'b1;
                    data_s    = INF_VALUE;
                    unreach_s = 1'b0;
                    index_s   = {ADDR_WIDTH{1'b0}};
                    busy_s    = 1'b1;
                end else if (out_ready) begin
                    valid_s = 1'b0;
                    neg_s   = 1'b0;
                    last_s  = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    valid_s = out_valid;
                end
            end
            default: begin
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Output and edge-detect registers
    always_ff @(posedge clock) begin
        if (reset) begin
            fin_r           <= 1'b0;
            neg_r           <= 1'b0;
            OMAR            <= {ADDR_WIDTH{1'b0}};
            out_valid       <= 1'b0;
            out_data        <= {DATA_WIDTH{1'b0}};
            out_index       <= {ADDR_WIDTH{1'b0}};
            out_unreachable <= 1'b0;
            out_last        <= 1'b0;
            out_neg         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            fin_r           <= Finish;
            neg_r           <= NegCycle;
            OMAR            <= omar_s;
            out_valid       <= valid_s;
            out_data        <= data_s;
            out_index       <= index_s;
            out_unreachable <= unreach_s;
            out_last        <= last_s;
            out_neg         <= neg_s;
            busy            <= busy_s;
            done            <= done_s;
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: a 3-word instance for protocol cases and a
// full 8192-word instance for the reset-abort and full-length stream.
module tb_result_streamer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Small instance (COUNT=3)
    logic        fin_a, neg_a, rdy_a;
    logic [12:0] omar_a, idx_a;
    logic [15:0] omdr_a, data_a;
    logic        valid_a, unr_a, last_a, nb_a, busy_a, done_a;
    logic [15:0] mem_a [0:2];
    assign omdr_a = (omar_a < 13'd3) ? mem_a[omar_a[1:0]] : 16'h0000;

    result_streamer #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .COUNT(3), .INF_VALUE(16'hFFFF)) dut_a (
        .clock(clock), .reset(reset), .Finish(fin_a), .NegCycle(neg_a),
        .OMAR(omar_a), .OMDR(omdr_a), .out_valid(valid_a), .out_ready(rdy_a),
        .out_data(data_a), .out_index(idx_a), .out_unreachable(unr_a),
        .out_last(last_a), .out_neg(nb_a), .busy(busy_a), .done(done_a));

    // Full-size instance (COUNT=8192)
    logic        fin_b, neg_b, rdy_b;
    logic [12:0] omar_b, idx_b;
    logic [15:0] omdr_b, data_b;
    logic        valid_b, unr_b, last_b, nb_b, busy_b, done_b;

    function automatic logic [15:0] bword(input logic [12:0] a);
        return 16'(a * 7 + 3);
    endfunction
    assign omdr_b = bword(omar_b);

    result_streamer #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .COUNT(8192), .INF_VALUE(16'hFFFF)) dut_b (
        .clock(clock), .reset(reset), .Finish(fin_b), .NegCycle(neg_b),
        .OMAR(omar_b), .OMDR(omdr_b), .out_valid(valid_b), .out_ready(rdy_b),
        .out_data(data_b), .out_index(idx_b), .out_unreachable(unr_b),
        .out_last(last_b), .out_neg(nb_b), .busy(busy_b), .done(done_b));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {last, unreachable, neg, index, data} of the small instance
    function automatic logic [31:0] beat_a();
        return {last_a, unr_a, nb_a, idx_a, data_a};
    endfunction

    function automatic logic [31:0] exp_beat_a(input int k);
        logic [15:0] d;
        d = (k == 0) ? 16'h0000 : (k == 1) ? 16'h0005 : 16'hFFFF;
        return {(k == 2), (k == 2), 1'b0, 13'(k), d};
    endfunction

    // Runs one full stream on the small instance; mode 1 toggles ready 1,0,0,1
    task automatic run_stream_a(input int mode);
        int k = 0;
        int cyc = 0;
        logic stall;
        logic [31:0] prev_beat;
        logic [12:0] prev_omar;
        fin_a = 1'b1;
        while (k < 3 && cyc < 60) begin
            rdy_a = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (valid_a && rdy_a) begin
                check("stream_beat", beat_a(), exp_beat_a(k));
                k++;
            end
            stall     = valid_a && !rdy_a;
            prev_beat = beat_a();
            prev_omar = omar_a;
            tick();
            cyc++;
            if (stall) begin
                check("stall_beat", {valid_a, beat_a()}, {1'b1, prev_beat});
                check("stall_omar", omar_a, prev_omar);
            end
        end
        check("stream_count", k, 3);
        check("stream_done", {done_a, busy_a, valid_a}, 3'b100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int k;
        logic [12:0] omar0;
        mem_a[0] = 16'h0000;
        mem_a[1] = 16'h0005;
        mem_a[2] = 16'hFFFF;
        fin_a = 1'b0; neg_a = 1'b0; rdy_a = 1'b0;
        fin_b = 1'b0; neg_b = 1'b0; rdy_b = 1'b0;
        reset = 1'b1;
        tick(); tick();
        check("reset_outputs", {valid_a, beat_a(), busy_a, done_a}, 35'd0);
        check("reset_omar", omar_a, 13'd0);
        reset = 1'b0;
        tick();

        // Test 1: exact latency with ready high
        fin_a = 1'b1; rdy_a = 1'b1;
        tick();
        check("t1_edge_cycle", {valid_a, busy_a, done_a}, 3'b010);
        tick();
        check("t1_beat0", {valid_a, beat_a()}, {1'b1, exp_beat_a(0)});
        tick();
        check("t1_beat1", {valid_a, beat_a()}, {1'b1, exp_beat_a(1)});
        tick();
        check("t1_beat2", {valid_a, beat_a()}, {1'b1, exp_beat_a(2)});
        tick();
        check("t1_done", {valid_a, busy_a, done_a}, 3'b001);
        fin_a = 1'b0; rdy_a = 1'b0;
        tick();

        // Test 2: back-pressure pattern
        run_stream_a(1);
        fin_a = 1'b0;
        tick();

        // Test 3: negative-cycle status beat
        neg_a = 1'b1; rdy_a = 1'b0;
        omar0 = omar_a;
        cnt = 0;
        tick();
        while (!valid_a && cnt < 10) begin
            check("t3_omar_hold", omar_a, omar0);
            tick();
            cnt++;
        end
        check("t3_neg_beat", {valid_a, beat_a()}, {1'b1, 1'b1, 1'b0, 1'b1, 13'd0, 16'hFFFF});
        check("t3_neg_busy", {busy_a, done_a}, 2'b10);
        rdy_a = 1'b1;
        tick();
        check("t3_neg_done", {valid_a, done_a, omar_a}, {1'b0, 1'b1, omar0});
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid_a) cnt++;
        end
        check("t3_single_beat", cnt, 0);
        neg_a = 1'b0; rdy_a = 1'b0;
        tick();

        // Test 4: simultaneous edges, neg wins; held Finish never streams
        fin_a = 1'b1; neg_a = 1'b1;
        cnt = 0;
        tick();
        while (!valid_a && cnt < 10) begin
            tick();
            cnt++;
        end
        check("t4_neg_wins", {valid_a, nb_a, last_a}, 3'b111);
        rdy_a = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid_a || busy_a) cnt++;
        end
        check("t4_no_stream", {cnt[7:0], done_a}, 9'd1);
        fin_a = 1'b0; neg_a = 1'b0; rdy_a = 1'b0;
        tick();

        // Test 6: one stream per rising edge, repeated stream identical
        run_stream_a(0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid_a || busy_a || !done_a) cnt++;
        end
        check("t6_held_high_idle", cnt, 0);
        fin_a = 1'b0;
        tick();
        run_stream_a(0);
        fin_a = 1'b0;

        // Test 5: reset mid-stream on the full-size instance, then full run
        fin_b = 1'b1; rdy_b = 1'b1;
        cnt = 0;
        while (!(valid_b && idx_b == 13'd4000) && cnt < 5000) begin
            tick();
            cnt++;
        end
        check("t5_reach_4000", {valid_b, idx_b}, {1'b1, 13'd4000});
        reset = 1'b1; fin_b = 1'b0;
        tick();
        check("t5_abort", {valid_b, busy_b, done_b}, 3'b000);
        reset = 1'b0;
        tick();
        check("t5_idle_after_reset", {valid_b, busy_b}, 2'b00);
        fin_b = 1'b1;
        k = 0; cnt = 0;
        while (k < 8192 && cnt < 9000) begin
            if (valid_b && rdy_b) begin
                check("t5_beat_ctl", {last_b, unr_b, nb_b, idx_b}, {(k == 8191), 1'b0, 1'b0, 13'(k)});
                check("t5_beat_data", data_b, bword(13'(k)));
                k++;
            end
            tick();
            cnt++;
        end
        check("t5_beat_count", k, 8192);
        check("t5_done", {valid_b, busy_b, done_b}, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
